// File: rtl/nes_input_pkg.sv
// rtl/nes_input_pkg.sv - shared constants for the NES controller port
// Purpose: SNES button indices, NES pad bit indices, $4016/$4017 select codes
//          and the default open-bus read value.
// Ports:   none (package)
package nes_input_pkg;

  // SNES serial order as delivered by the snes_controller readers
  localparam int SNES_B      = 0;
  localparam int SNES_Y      = 1;
  localparam int SNES_SELECT = 2;
  localparam int SNES_START  = 3;
  localparam int SNES_UP     = 4;
  localparam int SNES_DOWN   = 5;
  localparam int SNES_LEFT   = 6;
  localparam int SNES_RIGHT  = 7;
  localparam int SNES_A      = 8;
  localparam int SNES_X      = 9;
  localparam int SNES_L      = 10;
  localparam int SNES_R      = 11;

  // NES pad bit positions, bit 0 is the first one the CPU reads
  localparam int NES_A      = 0;
  localparam int NES_B      = 1;
  localparam int NES_SELECT = 2;
  localparam int NES_START  = 3;
  localparam int NES_UP     = 4;
  localparam int NES_DOWN   = 5;
  localparam int NES_LEFT   = 6;
  localparam int NES_RIGHT  = 7;

  localparam logic ADDR_4016 = 1'b0;
  localparam logic ADDR_4017 = 1'b1;

  localparam logic [7:0] OPEN_BUS_DEFAULT = 8'h40;

endpackage

// File: rtl/nes_joypad_shift.sv
// rtl/nes_joypad_shift.sv - 8-bit parallel-load, right-shift register with 1-fill
// Purpose: models the 4021 inside an NES pad; once all eight buttons have been
//          shifted out the output reads 1 until the next load.
// Ports:   CLK, CLR_N (async active-low), LOAD (parallel load, wins over SHIFT),
//          SHIFT (shift right one place), D[7:0] (load value), Q0 (current bit 0)
module nes_joypad_shift
  (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       LOAD,
  input  logic       SHIFT,
  input  logic [7:0] D,
  output logic       Q0
  );

  logic [7:0] r_sr;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_sr <= 8'h00;
    end else if (LOAD) begin
      r_sr <= D;
    end else if (SHIFT) begin
      r_sr <= {1'b1, r_sr[7:1]};
    end
  end

  assign Q0 = r_sr[0];

endmodule

// File: rtl/nes_joypad_port.sv
// rtl/nes_joypad_port.sv - CPU-facing NES controller port at $4016/$4017
// Purpose: syncs two SNES button vectors into CLK, maps them to the NES pad
//          layout, latches them while the strobe is high and returns one button
//          per CPU read. Optional turbo on X/Y under macro NES_JOYPAD_TURBO_EN.
// Ports:   CLK, CLR_N (async active-low reset), BUTTONS_A/BUTTONS_B[11:0]
//          (async SNES buttons), ADDR_SEL (0=$4016, 1=$4017), WR_EN, WR_DATA,
//          RD_EN, RD_DATA[7:0] (registered read data), STROBE (latch state)
module nes_joypad_port
  import nes_input_pkg::*;
  #(
  parameter logic [19:0] TURBO_DIV = 20'd833333,
  parameter logic [7:0]  OPEN_BUS  = OPEN_BUS_DEFAULT
  )
  (
  input  logic        CLK,
  input  logic        CLR_N,
  input  logic [11:0] BUTTONS_A,
  input  logic [11:0] BUTTONS_B,
  input  logic        ADDR_SEL,
  input  logic        WR_EN,
  input  logic        WR_DATA,
  input  logic        RD_EN,
  output logic [7:0]  RD_DATA,
  output logic        STROBE
  );

  logic [11:0] r_btn_a_s1, r_btn_a_s2;
  logic [11:0] r_btn_b_s1, r_btn_b_s2;
  logic        r_strobe;
  logic [7:0]  r_rd_data;

  logic [7:0]  w_nes_a, w_nes_b;
  logic        w_shift_a, w_shift_b;
  logic        w_q0_a, w_q0_b;
  logic        w_rd_bit;
  logic        w_turbo_phase;
  logic        w_unused;

  // Two-flop synchronisers; the readers run on their own clock
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_btn_a_s1 <= 12'h000;
      r_btn_a_s2 <= 12'h000;
      r_btn_b_s1 <= 12'h000;
      r_btn_b_s2 <= 12'h000;
    end else begin
      r_btn_a_s1 <= BUTTONS_A;
      r_btn_a_s2 <= r_btn_a_s1;
      r_btn_b_s1 <= BUTTONS_B;
      r_btn_b_s2 <= r_btn_b_s1;
    end
  end

`ifdef NES_JOYPAD_TURBO_EN
  logic [19:0] r_turbo_cnt;
  logic        r_turbo_phase;

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_turbo_cnt   <= 20'd0;
      r_turbo_phase <= 1'b0;
    end else if (r_turbo_cnt == TURBO_DIV - 20'd1) begin
      r_turbo_cnt   <= 20'd0;
      r_turbo_phase <= ~r_turbo_phase;
    end else begin
      r_turbo_cnt   <= r_turbo_cnt + 20'd1;
    end
  end

  assign w_turbo_phase = r_turbo_phase;
  assign w_unused = ^{r_btn_a_s2[SNES_L], r_btn_a_s2[SNES_R],
                      r_btn_b_s2[SNES_L], r_btn_b_s2[SNES_R]};
`else
  assign w_turbo_phase = 1'b0;
  assign w_unused = ^{r_btn_a_s2[SNES_L], r_btn_a_s2[SNES_R],
                      r_btn_a_s2[SNES_X], r_btn_a_s2[SNES_Y],
                      r_btn_b_s2[SNES_L], r_btn_b_s2[SNES_R],
                      r_btn_b_s2[SNES_X], r_btn_b_s2[SNES_Y],
                      w_turbo_phase};
`endif

  // SNES -> NES mapping; X/Y only feed A/B through the turbo phase
  always_comb begin
    w_nes_a = 8'h00;
    w_nes_a[NES_A]      = r_btn_a_s2[SNES_A];
    w_nes_a[NES_B]      = r_btn_a_s2[SNES_B];
    w_nes_a[NES_SELECT] = r_btn_a_s2[SNES_SELECT];
    w_nes_a[NES_START]  = r_btn_a_s2[SNES_START];
    w_nes_a[NES_UP]     = r_btn_a_s2[SNES_UP];
    w_nes_a[NES_DOWN]   = r_btn_a_s2[SNES_DOWN];
    w_nes_a[NES_LEFT]   = r_btn_a_s2[SNES_LEFT];
    w_nes_a[NES_RIGHT]  = r_btn_a_s2[SNES_RIGHT];
`ifdef NES_JOYPAD_TURBO_EN
    w_nes_a[NES_A] = w_nes_a[NES_A] | (r_btn_a_s2[SNES_X] & w_turbo_phase);
    w_nes_a[NES_B] = w_nes_a[NES_B] | (r_btn_a_s2[SNES_Y] & w_turbo_phase);
`endif
  end

  always_comb begin
    w_nes_b = 8'h00;
    w_nes_b[NES_A]      = r_btn_b_s2[SNES_A];
    w_nes_b[NES_B]      = r_btn_b_s2[SNES_B];
    w_nes_b[NES_SELECT] = r_btn_b_s2[SNES_SELECT];
    w_nes_b[NES_START]  = r_btn_b_s2[SNES_START];
    w_nes_b[NES_UP]     = r_btn_b_s2[SNES_UP];
    w_nes_b[NES_DOWN]   = r_btn_b_s2[SNES_DOWN];
    w_nes_b[NES_LEFT]   = r_btn_b_s2[SNES_LEFT];
    w_nes_b[NES_RIGHT]  = r_btn_b_s2[SNES_RIGHT];
`ifdef NES_JOYPAD_TURBO_EN
    w_nes_b[NES_A] = w_nes_b[NES_A] | (r_btn_b_s2[SNES_X] & w_turbo_phase);
    w_nes_b[NES_B] = w_nes_b[NES_B] | (r_btn_b_s2[SNES_Y] & w_turbo_phase);
`endif
  end

  // Only $4016 writes touch the strobe; $4017 writes belong to the APU
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_strobe <= 1'b0;
    end else if (WR_EN && (ADDR_SEL == ADDR_4016)) begin
      r_strobe <= WR_DATA;
    end
  end

  // Shift decision uses the pre-write strobe, so a same-cycle write cannot
  // suppress or trigger the shift of the read it accompanies
  assign w_shift_a = RD_EN && !r_strobe && (ADDR_SEL == ADDR_4016);
  assign w_shift_b = RD_EN && !r_strobe && (ADDR_SEL == ADDR_4017);

  nes_joypad_shift u_shift_a (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .LOAD  (r_strobe),
    .SHIFT (w_shift_a),
    .D     (w_nes_a),
    .Q0    (w_q0_a)
  );

  nes_joypad_shift u_shift_b (
    .CLK   (CLK),
    .CLR_N (CLR_N),
    .LOAD  (r_strobe),
    .SHIFT (w_shift_b),
    .D     (w_nes_b),
    .Q0    (w_q0_b)
  );

  // While strobed the pad is transparent: return the live A button rather than
  // the copy loaded into the register one cycle earlier
  always_comb begin
    w_rd_bit = 1'b0;
    if (r_strobe) begin
      w_rd_bit = (ADDR_SEL == ADDR_4017) ? w_nes_b[NES_A] : w_nes_a[NES_A];
    end else begin
      w_rd_bit = (ADDR_SEL == ADDR_4017) ? w_q0_b : w_q0_a;
    end
  end

  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      r_rd_data <= 8'h00;
    end else if (RD_EN) begin
      r_rd_data <= {OPEN_BUS[7:5], 4'b0000, w_rd_bit};
    end
  end

  assign RD_DATA = r_rd_data;
  assign STROBE  = r_strobe;

endmodule

// File: tb/tb_nes_joypad_port.sv
// tb/tb_nes_joypad_port.sv - scoreboard bench for nes_joypad_port
module tb_nes_joypad_port;

  logic        clk;
  logic        clr_n;
  logic [11:0] btn_a, btn_b;
  logic        addr_sel, wr_en, wr_data, rd_en;
  logic [7:0]  rd_data;
  logic        strobe;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic       rd_pend;

  // reference model state
  logic       m_strobe;
  logic [7:0] m_vec[2];
  int         m_cnt[2];

  nes_joypad_port dut (
    .CLK       (clk),
    .CLR_N     (clr_n),
    .BUTTONS_A (btn_a),
    .BUTTONS_B (btn_b),
    .ADDR_SEL  (addr_sel),
    .WR_EN     (wr_en),
    .WR_DATA   (wr_data),
    .RD_EN     (rd_en),
    .RD_DATA   (rd_data),
    .STROBE    (strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // NES pad order, bit 0 first: A, B, Select, Start, Up, Down, Left, Right
  function automatic logic [7:0] nes_map(input logic [11:0] s);
    return {s[7], s[6], s[5], s[4], s[3], s[2], s[0], s[8]};
  endfunction

  function automatic logic model_read(input int p);
    logic [7:0] v;
    logic       r;
    if (m_strobe) begin
      v = nes_map(p == 1 ? btn_b : btn_a);
      return v[0];
    end
    r = (m_cnt[p] < 8) ? m_vec[p][m_cnt[p]] : 1'b1;
    m_cnt[p]++;
    return r;
  endfunction

  task automatic model_write(input logic sel, input logic d);
    if (sel == 1'b0) begin
      if (m_strobe && !d) begin
        m_vec[0] = nes_map(btn_a);
        m_vec[1] = nes_map(btn_b);
        m_cnt[0] = 0;
        m_cnt[1] = 0;
      end
      m_strobe = d;
    end
  endtask

  task automatic model_reset();
    m_strobe = 1'b0;
    m_vec[0] = 8'h00;
    m_vec[1] = 8'h00;
    m_cnt[0] = 0;
    m_cnt[1] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One bus cycle; the read is modelled before the write (pre-write state)
  task automatic do_op(input logic rd, input logic wr, input logic sel, input logic d,
                       input logic use_exp, input logic [7:0] exp);
    logic b;
    addr_sel = sel;
    rd_en    = rd;
    wr_en    = wr;
    wr_data  = d;
    if (rd) begin
      b = model_read(sel ? 1 : 0);
      exp_q.push_back(use_exp ? exp : (8'h40 | {7'd0, b}));
    end
    if (wr) model_write(sel, d);
    @(negedge clk);
    rd_en = 1'b0;
    wr_en = 1'b0;
    chk("strobe", {7'd0, strobe}, {7'd0, m_strobe});
  endtask

  task automatic rd(input logic sel);
    do_op(1'b1, 1'b0, sel, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic rd_exp(input logic sel, input logic [7:0] e);
    do_op(1'b1, 1'b0, sel, 1'b0, 1'b1, e);
  endtask

  task automatic wr(input logic sel, input logic d);
    do_op(1'b0, 1'b1, sel, d, 1'b0, 8'h00);
  endtask

  // Monitor: RD_DATA is due the cycle after each RD_EN
  always @(posedge clk) rd_pend <= rd_en;

  always @(negedge clk) begin
    if (rd_pend === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_underflow", 8'h01, 8'h00);
      end else begin
        chk("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  logic [7:0] seq1[10] = '{8'h41, 8'h41, 8'h40, 8'h41, 8'h40,
                           8'h40, 8'h40, 8'h40, 8'h41, 8'h41};

  initial begin
    int op;
    logic s, d;
    clr_n = 1'b0; btn_a = 12'h000; btn_b = 12'h000;
    addr_sel = 1'b0; wr_en = 1'b0; wr_data = 1'b0; rd_en = 1'b0;
    model_reset();
    idle(3);
    chk("reset_rd_data", rd_data, 8'h00);
    chk("reset_strobe", {7'd0, strobe}, 8'h00);
    clr_n = 1'b1;
    idle(2);

    // Full read sequence with A, B, Start pressed
    btn_a = 12'h109;
    idle(3);
    wr(1'b0, 1'b1);
    wr(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) rd_exp(1'b0, seq1[i]);

    // Strobe held high: each read returns the live A button
    wr(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      btn_a = btn_a ^ 12'h100;
      idle(3);
      rd_exp(1'b0, btn_a[8] ? 8'h41 : 8'h40);
    end
    wr(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) rd(1'b0);

    // Player isolation
    btn_a = 12'h109;
    btn_b = 12'h080;
    idle(3);
    wr(1'b0, 1'b1);
    wr(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) rd(1'b0);
    for (int i = 0; i < 8; i++) rd_exp(1'b1, (i == 7) ? 8'h41 : 8'h40);
    for (int i = 0; i < 6; i++) rd(1'b0);

    // Simultaneous read and write-1 after two bits shifted out
    btn_a = 12'h10D;
    idle(3);
    wr(1'b0, 1'b1);
    wr(1'b0, 1'b0);
    rd(1'b0);
    rd(1'b0);
    do_op(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h41);
    rd_exp(1'b0, 8'h41);
    wr(1'b0, 1'b0);

    // Reset mid-sequence
    wr(1'b0, 1'b1);
    wr(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) rd(1'b0);
    idle(1);
    clr_n = 1'b0;
    #1;
    chk("midreset_rd_data", rd_data, 8'h00);
    chk("midreset_strobe", {7'd0, strobe}, 8'h00);
    model_reset();
    @(negedge clk);
    clr_n = 1'b1;
    rd_exp(1'b0, 8'h40);
    idle(3);

`ifndef NES_JOYPAD_TURBO_EN
    // X held, A released: no turbo in this build, A reads stay 0
    btn_a = 12'h200;
    idle(3);
    wr(1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      rd_exp(1'b0, 8'h40);
      idle($urandom_range(0, 3));
    end
    wr(1'b0, 1'b0);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      s  = ($urandom_range(0, 3) == 0);
      d  = $urandom_range(0, 1);
      case (op)
        0: begin
          btn_a = 12'($urandom);
          btn_b = 12'($urandom);
          idle(3);
        end
        1, 2: wr(s, d);
        8:    do_op(1'b1, 1'b1, s, d, 1'b0, 8'h00);
        9:    idle($urandom_range(0, 2));
        default: rd(s);
      endcase
    end

    idle(3);
    chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
